// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the CDC transmit arbiter: state encoding, default
// parameter values and the hold/gap counter sizing helper.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 3;
    // Destination synchronizer depth; HOLD and GAP must each be at least this + 1.
    localparam int SYNC_STAGES     = 2;

    // Bits needed by a down-counter that is loaded with max(hold, gap) - 1.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cdc_rr_picker.sv
// Combinational round-robin selector: first requester at or after
// last_grant+1 (modulo NREQ) wins.
module cdc_rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] index
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  cand [NREQ];
    logic [NREQ-1:0] hit;

    // cand[gi] is the requester examined at priority position gi.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IDW:0] sum;
        assign sum       = {1'b0, last_grant} + (IDW+1)'(gi + 1);
        assign cand[gi]  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                   : sum[IDW-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        valid = |hit;
        index = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                index = cand[i];
            end
        end
    end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Source-domain arbiter feeding a mux-select synchronizer: captures one
// requester's data, holds it with bus_enable high, then enforces a low gap.
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                    CdcArb_CLK,
    input  logic                    CdcArb_RST,
    input  logic [NREQ-1:0]         CdcArb_req,
    input  logic [NREQ*WIDTH-1:0]   CdcArb_data,
    output logic [NREQ-1:0]         CdcArb_ack,
    output logic [WIDTH-1:0]        CdcArb_unsync_bus,
    output logic                    CdcArb_bus_enable,
    output logic [$clog2(NREQ)-1:0] CdcArb_src_id,
    output logic                    CdcArb_busy
);
    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    arb_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDW-1:0]   last_grant_reg;
    logic [NREQ-1:0]  ack_reg;
    logic [WIDTH-1:0] bus_reg;
    logic             en_reg;
    logic [IDW-1:0]   src_reg;

    logic             pick_valid;
    logic [IDW-1:0]   pick_index;
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
        assign data_arr[gi] = CdcArb_data[gi*WIDTH +: WIDTH];
    end

    cdc_rr_picker #(.NREQ(NREQ)) u_picker (
        .req        (CdcArb_req),
        .last_grant (last_grant_reg),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    always_ff @(posedge CdcArb_CLK or negedge CdcArb_RST) begin
        if (!CdcArb_RST) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= IDW'(NREQ - 1);
            ack_reg        <= '0;
            bus_reg        <= '0;
            en_reg         <= 1'b0;
            src_reg        <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    // Requests are only looked at here, so HOLD/GAP ignore them.
                    if (pick_valid) begin
                        state_reg      <= ST_HOLD;
                        cnt_reg        <= CNT_W'(HOLD_CYCLES - 1);
                        bus_reg        <= data_arr[pick_index];
                        src_reg        <= pick_index;
                        last_grant_reg <= pick_index;
                        ack_reg        <= NREQ'(1) << pick_index;
                        en_reg         <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_GAP;
                        cnt_reg   <= CNT_W'(GAP_CYCLES - 1);
                        en_reg    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    en_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign CdcArb_ack        = ack_reg;
    assign CdcArb_unsync_bus = bus_reg;
    assign CdcArb_bus_enable = en_reg;
    assign CdcArb_src_id     = src_reg;
    assign CdcArb_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter (NREQ=4, WIDTH=8, HOLD=4, GAP=3): a vector
// table for arbitration order plus hand-written reset and gap-timing sequences.
module tb_cdc_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  ack;
    logic [7:0]  bus;
    logic        en;
    logic [1:0]  sid;
    logic        busy;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] D = 32'h4332_2110;

    cdc_tx_arbiter #(
        .NREQ(4), .WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(3)
    ) dut (
        .CdcArb_CLK        (clk),
        .CdcArb_RST        (rst_n),
        .CdcArb_req        (req),
        .CdcArb_data       (data),
        .CdcArb_ack        (ack),
        .CdcArb_unsync_bus (bus),
        .CdcArb_bus_enable (en),
        .CdcArb_src_id     (sid),
        .CdcArb_busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_ack(input string name, output int ack_cyc, output logic ok);
        ok = 1'b0;
        ack_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                ok = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        if (!ok) check({name, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    // Follows one transfer from its ack to the return to IDLE.
    task automatic run_xfer(input string name, input int exp_id, input logic [7:0] exp_bus,
                            input bit drop, output int ack_cyc);
        logic ok;
        int   hi, lo;
        bit   unstable, extra_ack;
        wait_ack(name, ack_cyc, ok);
        if (!ok) return;
        check({name, "_ack"}, 32'(ack), 32'd1 << exp_id);
        check({name, "_src_id"}, 32'(sid), 32'(exp_id));
        check({name, "_bus"}, 32'(bus), 32'(exp_bus));
        if (drop) req[exp_id] = 1'b0;
        hi = 0; lo = 0; unstable = 0; extra_ack = 0;
        while (en === 1'b1 && hi < 20) begin
            if (bus !== exp_bus || sid !== 2'(exp_id) || busy !== 1'b1) unstable = 1;
            hi++;
            @(negedge clk);
            if (ack !== 4'b0) extra_ack = 1;
        end
        while (busy === 1'b1 && en === 1'b0 && lo < 20) begin
            lo++;
            @(negedge clk);
            if (ack !== 4'b0) extra_ack = 1;
        end
        check({name, "_hold_len"}, 32'(hi), 32'd4);
        check({name, "_gap_len"}, 32'(lo), 32'd3);
        check({name, "_stable"}, 32'(unstable), 32'd0);
        check({name, "_single_ack"}, 32'(extra_ack), 32'd0);
        check({name, "_idle"}, {30'd0, busy, en}, 32'd0);
        $display("xfer %s: id=%0d bus=0x%0h ack_cycle=%0d", name, sid, bus, ack_cyc);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_bus;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   t, t_prev, g;
        logic ok;
        bit   early;

        vecs[0] = '{4'b0010, 32'h0000_A500, 1, 8'hA5};
        vecs[1] = '{4'b0101, D, 2, 8'h32};
        vecs[2] = '{4'b0101, D, 0, 8'h10};
        vecs[3] = '{4'b1001, D, 3, 8'h43};
        vecs[4] = '{4'b0011, D, 0, 8'h10};
        vecs[5] = '{4'b0001, D, 0, 8'h10};
        vecs[6] = '{4'b1000, D, 3, 8'h43};

        // Reset state, both during and after reset.
        req = 4'b1111; data = D;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, ack, bus, en, busy}, 32'd0);
        check("reset_src_id", 32'(sid), 32'd0);
        req = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {19'd0, ack, bus, en, busy}, 32'd0);

        // Table-driven arbitration; round-robin state carries from row to row.
        for (int i = 0; i < 7; i++) begin
            req  = vecs[i].req;
            data = vecs[i].data;
            run_xfer($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_bus, 1'b1, t);
            req = '0;
        end

        // All four request together and drop on ack: 0,1,2,3 every 8 cycles.
        pulse_reset();
        req = 4'b1111; data = D;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_xfer($sformatf("all%0d", i), i, D[i*8 +: 8], 1'b1, t);
            if (i > 0) check($sformatf("all%0d_spacing", i), 32'(t - t_prev), 32'd8);
            t_prev = t;
        end
        req = '0;

        // Requesters 0 and 2 held continuously alternate.
        pulse_reset();
        req = 4'b0101; data = D;
        for (int i = 0; i < 4; i++) begin
            run_xfer($sformatf("alt%0d", i), (i % 2) * 2, D[((i % 2) * 2) * 8 +: 8], 1'b0, t);
            if (i > 0) check($sformatf("alt%0d_spacing", i), 32'(t - t_prev), 32'd8);
            t_prev = t;
        end
        req = '0;

        // Reset in the second HOLD cycle aborts the transfer; req[3] then wins.
        pulse_reset();
        req = 4'b1001; data = D;
        wait_ack("rst_mid", t, ok);
        check("rst_mid_first_ack", 32'(ack), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_in_hold", {30'd0, busy, en}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cleared", {19'd0, ack, bus, en, busy}, 32'd0);
        check("rst_mid_src_id", 32'(sid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer("rst_after", 3, 8'h43, 1'b1, t);

        // req[2] rising during GAP waits for IDLE and takes the capture-edge data.
        req = 4'b0010; data = 32'h0000_5A00;
        wait_ack("gap_first", t, ok);
        check("gap_first_id", 32'(sid), 32'd1);
        req[1] = 1'b0;
        g = 0;
        while (en === 1'b1 && g < 20) begin
            g++;
            @(negedge clk);
        end
        req[2] = 1'b1;
        g = 0; early = 0;
        while (busy === 1'b1 && g < 20) begin
            if (ack !== 4'b0) early = 1;
            data[23:16] = 8'h11 * 8'(g + 1);
            g++;
            @(negedge clk);
        end
        check("gap_no_early_ack", 32'(early), 32'd0);
        check("gap_cycles_seen", 32'(g), 32'd3);
        data[23:16] = 8'hC3;
        run_xfer("gap_late", 2, 8'hC3, 1'b1, t);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
